// File: rtl/riscv_pkg.sv
// Shared core types: issue controller states and register-index widths.
package riscv_pkg;

  localparam int unsigned ISSUE_CNT_W = 2;
  localparam int unsigned REG_ADR_W   = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } issue_state_t;

endpackage

// File: rtl/issue_ctrl_cnt.sv
// One scoreboard entry: saturating up/down in-flight write counter with clear.
module issue_ctrl_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero,
  output logic             o_max
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_zero;
  logic             w_max;

  assign w_zero = (r_cnt == '0);
  assign w_max  = (r_cnt == '1);

  // Simultaneous inc and dec cancel; the ends of the range hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !w_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && !w_zero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = w_zero;
  assign o_max  = w_max;

endmodule

// File: rtl/issue_ctrl.sv
// Issue gate with per-register in-flight scoreboard, RAW/WAW stalls and CSR serialisation.
// Optional: define ISSUE_CTRL_BYPASS_EN to waive RAW on a register retiring its last write.
module issue_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned NB_REG = 32,
  parameter int unsigned CNT_W  = ISSUE_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic                 rs1_v_i,
  input  logic [REG_ADR_W-1:0] rs1_adr_i,
  input  logic                 rs2_v_i,
  input  logic [REG_ADR_W-1:0] rs2_adr_i,
  input  logic                 rd_v_i,
  input  logic [REG_ADR_W-1:0] rd_adr_i,
  input  logic                 csr_i,
  input  logic                 exe_ready_i,
  output logic                 issue_valid_o,
  input  logic                 wbk_v_i,
  input  logic [REG_ADR_W-1:0] wbk_adr_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 busy_o,
  output logic                 err_o
);

  issue_state_t     r_state;
  issue_state_t     w_state_nxt;
  logic             r_err;

  logic [NB_REG-1:0] w_zero;
  logic [NB_REG-1:0] w_max;
  logic [NB_REG-1:0] w_inc;
  logic [NB_REG-1:0] w_dec;
  logic [NB_REG-1:0] w_left;
  logic [CNT_W-1:0]  w_cnt [NB_REG];

  logic w_empty;
  logic w_empty_nxt;
  logic w_wbk;
  logic w_err_set;
  logic w_byp1;
  logic w_byp2;
  logic w_raw;
  logic w_sat;
  logic w_state_ok;
  logic w_issue;

  // x0 is hard-wired: never busy, never saturated.
  assign w_zero[0] = 1'b1;
  assign w_max[0]  = 1'b0;
  assign w_cnt[0]  = '0;

  for (genvar g = 1; g < NB_REG; g++) begin : g_cnt
    issue_ctrl_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (w_inc[g]),
      .i_dec  (w_dec[g]),
      .i_clr  (flush_i),
      .o_cnt  (w_cnt[g]),
      .o_zero (w_zero[g]),
      .o_max  (w_max[g])
    );
  end

  assign w_empty   = &w_zero;
  assign w_wbk     = wbk_v_i & ~flush_i;
  assign w_err_set = w_wbk & (wbk_adr_i != '0) & w_zero[wbk_adr_i];

`ifdef ISSUE_CTRL_BYPASS_EN
  assign w_byp1 = w_wbk & (wbk_adr_i == rs1_adr_i) & (w_cnt[rs1_adr_i] == CNT_W'(1));
  assign w_byp2 = w_wbk & (wbk_adr_i == rs2_adr_i) & (w_cnt[rs2_adr_i] == CNT_W'(1));
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_raw = (rs1_v_i & ~w_zero[rs1_adr_i] & ~w_byp1)
               | (rs2_v_i & ~w_zero[rs2_adr_i] & ~w_byp2);
  assign w_sat = rd_v_i & w_max[rd_adr_i];

  // Which instructions the current state lets through.
  always_comb begin
    w_state_ok = 1'b0;
    case (r_state)
      RUN:     w_state_ok = ~csr_i | w_empty;
      DRAIN:   w_state_ok = csr_i & w_empty;
      default: w_state_ok = 1'b0;
    endcase
  end

  assign w_issue = ~reset & dec_valid_i & exe_ready_i & ~flush_i
                 & ~w_raw & ~w_sat & w_state_ok;

  // Per-register increment/decrement and "still busy after this edge".
  always_comb begin
    w_inc  = '0;
    w_dec  = '0;
    w_left = '0;
    for (int unsigned i = 1; i < NB_REG; i++) begin
      w_inc[i]  = w_issue & rd_v_i & (rd_adr_i == REG_ADR_W'(i));
      w_dec[i]  = w_wbk & (wbk_adr_i == REG_ADR_W'(i)) & ~w_zero[i];
      w_left[i] = ~w_zero[i] & ~(w_dec[i] & (w_cnt[i] == CNT_W'(1)));
    end
  end

  assign w_empty_nxt = ~|w_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_err_set;
    end
  end

  // SERIAL holds until the scoreboard drains; no issue happens there.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_issue && csr_i)            w_state_nxt = SERIAL;
          else if (dec_valid_i && csr_i)   w_state_nxt = DRAIN;
        end
        DRAIN: begin
          if (w_issue)                     w_state_nxt = SERIAL;
        end
        SERIAL: begin
          if (w_empty_nxt)                 w_state_nxt = RUN;
        end
        default:                           w_state_nxt = RUN;
      endcase
    end
  end

  assign issue_valid_o = w_issue;
  assign dec_ready_o   = w_issue;
  assign stall_o       = ~reset & dec_valid_i & ~w_issue;
  assign busy_o        = ~w_empty | (r_state != RUN);
  assign err_o         = r_err;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus random traffic against a counter-array model.
module tb_issue_ctrl;

  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid_i, dec_ready_o;
  logic       rs1_v_i, rs2_v_i, rd_v_i;
  logic [4:0] rs1_adr_i, rs2_adr_i, rd_adr_i;
  logic       csr_i, exe_ready_i, issue_valid_o;
  logic       wbk_v_i;
  logic [4:0] wbk_adr_i;
  logic       flush_i, stall_o, busy_o, err_o;

  int n_total = 0;
  int n_bad   = 0;

  // Model: in-flight writes per register, mode 0=RUN 1=DRAIN 2=SERIAL, sticky error.
  int m_cnt [32];
  int m_st;
  bit m_err;

  issue_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid_i   (dec_valid_i),
    .dec_ready_o   (dec_ready_o),
    .rs1_v_i       (rs1_v_i),
    .rs1_adr_i     (rs1_adr_i),
    .rs2_v_i       (rs2_v_i),
    .rs2_adr_i     (rs2_adr_i),
    .rd_v_i        (rd_v_i),
    .rd_adr_i      (rd_adr_i),
    .csr_i         (csr_i),
    .exe_ready_i   (exe_ready_i),
    .issue_valid_o (issue_valid_o),
    .wbk_v_i       (wbk_v_i),
    .wbk_adr_i     (wbk_adr_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int total();
    int s = 0;
    for (int r = 0; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_st  = 0;
    m_err = 1'b0;
  endtask

  function automatic bit hazard(input logic [4:0] r);
    if (m_cnt[r] == 0) return 1'b0;
`ifdef ISSUE_CTRL_BYPASS_EN
    if (wbk_v_i && wbk_adr_i == r && m_cnt[r] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit model_issue();
    bit ok;
    case (m_st)
      0:       ok = !csr_i || total() == 0;
      1:       ok = csr_i && total() == 0;
      default: ok = 1'b0;
    endcase
    return dec_valid_i && exe_ready_i && !flush_i
        && !(rs1_v_i && hazard(rs1_adr_i))
        && !(rs2_v_i && hazard(rs2_adr_i))
        && !(rd_v_i && m_cnt[rd_adr_i] == MAXC) && ok;
  endfunction

  task automatic model_edge(input bit iss);
    if (flush_i) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_st = 0;
    end else begin
      if (wbk_v_i && wbk_adr_i != 0) begin
        if (m_cnt[wbk_adr_i] == 0) m_err = 1'b1;
        else m_cnt[wbk_adr_i]--;
      end
      if (iss && rd_v_i && rd_adr_i != 0) m_cnt[rd_adr_i]++;
      case (m_st)
        0: if (iss && csr_i) m_st = 2; else if (dec_valid_i && csr_i) m_st = 1;
        1: if (iss) m_st = 2;
        default: if (total() == 0) m_st = 0;
      endcase
    end
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one cycle.
  task automatic step();
    bit e_iss;
    #1;
    e_iss = model_issue();
    chk("issue", issue_valid_o, e_iss);
    chk("ready", dec_ready_o, e_iss);
    chk("stall", stall_o, dec_valid_i && !e_iss);
    chk("busy", busy_o, total() != 0 || m_st != 0);
    chk("err", err_o, m_err);
    @(posedge clk);
    model_edge(e_iss);
    @(negedge clk);
  endtask

  task automatic drv(input bit dv, input bit r1v, input int r1, input bit r2v, input int r2,
                     input bit rdv, input int rd, input bit csr, input bit wv, input int wa,
                     input bit fl);
    dec_valid_i = dv;  rs1_v_i = r1v; rs1_adr_i = 5'(r1);
    rs2_v_i = r2v;     rs2_adr_i = 5'(r2);
    rd_v_i = rdv;      rd_adr_i = 5'(rd);
    csr_i = csr;       exe_ready_i = 1'b1;
    wbk_v_i = wv;      wbk_adr_i = 5'(wa);
    flush_i = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && total() != 0; k++) begin
      int w = 0;
      for (int r = 31; r > 0; r--) if (m_cnt[r] != 0) w = r;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, w, 0);
      step();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    #1;
    chk("rst_issue", issue_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // RAW on x5
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); step();
    drv(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
    #1 chk("raw_stall", stall_o, 1'b1); step();
    step();
    drv(1, 1, 5, 0, 0, 1, 6, 0, 1, 5, 0);
`ifdef ISSUE_CTRL_BYPASS_EN
    #1 chk("raw_bypass", issue_valid_o, 1'b1); step();
`else
    #1 chk("raw_wbk_cycle", stall_o, 1'b1); step();
    drv(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
    #1 chk("raw_release", issue_valid_o, 1'b1); step();
`endif
    drain();

    // WAW saturation on x7
    for (int k = 0; k < 3; k++) begin
      drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0); step();
    end
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    #1 chk("waw_sat", stall_o, 1'b1); step();
    drv(1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0); step();
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    #1 chk("waw_release", issue_valid_o, 1'b1); step();
    drain();

    // CSR serialisation
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); step();
    drv(1, 1, 1, 0, 0, 1, 10, 1, 0, 0, 0);
    #1 chk("csr_wait", stall_o, 1'b1); step();
    drv(1, 1, 1, 0, 0, 1, 10, 1, 1, 3, 0);
    #1 chk("csr_drain_busy", busy_o, 1'b1); step();
    drv(1, 1, 1, 0, 0, 1, 10, 1, 0, 0, 0);
    #1 chk("csr_issue", issue_valid_o, 1'b1); step();
    drv(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    #1 chk("serial_stall", stall_o, 1'b1); step();
    drv(1, 1, 1, 0, 0, 1, 2, 0, 1, 10, 0); step();
    drv(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    #1 chk("serial_done", issue_valid_o, 1'b1); step();
    drain();

    // Flush clears tracking
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0); step();
    drv(1, 1, 1, 1, 2, 1, 3, 0, 1, 8, 1);
    #1 chk("flush_noissue", issue_valid_o, 1'b0); step();
    drv(1, 1, 1, 1, 2, 1, 3, 0, 0, 0, 0);
    #1 chk("flush_busy", busy_o, 1'b0);
    chk("flush_err", err_o, 1'b0);
    chk("flush_dep", issue_valid_o, 1'b1); step();
    drain();

    // Simultaneous inc/dec on x9, then error writeback on x4
    drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 1, 9, 0, 1, 9, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    #1 chk("same_busy", busy_o, 1'b1); step();
    idle();
    #1 chk("same_empty", busy_o, 1'b0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0); step();
    idle();
    #1 chk("err_set", err_o, 1'b1); step();
    step();
    #1 chk("err_sticky", err_o, 1'b1);

    // Async reset in SERIAL with x12 in flight
    drv(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0); step();
    drv(1, 1, 12, 0, 0, 1, 13, 0, 0, 0, 0);
    #1 chk("pre_rst_stall", stall_o, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_issue", issue_valid_o, 1'b0);
    chk("arst_ready", dec_ready_o, 1'b0);
    chk("arst_stall", stall_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_err", err_o, 1'b0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("post_rst_issue", issue_valid_o, 1'b1); step();
    drain();

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int q[$];
      dec_valid_i = ($urandom_range(0, 99) < 80);
      rs1_v_i     = $urandom_range(0, 1) == 1;
      rs1_adr_i   = 5'($urandom_range(0, 7));
      rs2_v_i     = $urandom_range(0, 1) == 1;
      rs2_adr_i   = 5'($urandom_range(0, 7));
      rd_v_i      = ($urandom_range(0, 99) < 70);
      rd_adr_i    = 5'($urandom_range(0, 7));
      csr_i       = ($urandom_range(0, 99) < ((m_st == 1) ? 70 : 8));
      exe_ready_i = ($urandom_range(0, 99) < 85);
      flush_i     = ($urandom_range(0, 99) < 3);
      wbk_v_i     = $urandom_range(0, 1) == 1;
      for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) q.push_back(r);
      if (q.size() != 0 && $urandom_range(0, 99) < 90)
        wbk_adr_i = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        wbk_adr_i = 5'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
